// File: rtl/calc_result_display_formatter_pkg.sv
// Shared constants for the result display formatter:
// digit codes, FSM encoding and code packing width.
package calc_result_display_formatter_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] DIG_BLANK = 4'hF;
  localparam logic [CODE_W-1:0] DIG_MINUS = 4'hA;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_FORMAT = 2'd3;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble correction: add 3 to every
// BCD digit that is 5 or more, ahead of the shift.
module bcd_dabble_step #(
  parameter int NDIG = 6
) (
  input  logic [NDIG*4-1:0] bcd_in,
  output logic [NDIG*4-1:0] bcd_out
);

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    logic [3:0] d;
    assign d = bcd_in[g*4 +: 4];
    assign bcd_out[g*4 +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
  end

endmodule

// File: rtl/calc_result_display_formatter.sv
// Signed result to six seven-segment digit codes via
// iterative double-dabble, blanking and sign placement.
module calc_result_display_formatter
  import calc_result_display_formatter_pkg::*;
#(
  parameter int BIN_WIDTH   = 18,
  parameter int BCD_DIGITS  = 5,
  parameter int DISP_DIGITS = 6
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          CONVERT,
  input  logic [BIN_WIDTH-1:0]          BIN_IN,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [DISP_DIGITS*CODE_W-1:0] DIGIT_CODE,
  output logic                          NEGATIVE,
  output logic                          OVERFLOW
);

  localparam int BCD_W = (BCD_DIGITS + 1) * 4;
  localparam int CNT_W = $clog2(BIN_WIDTH);
  localparam int OUT_W = DISP_DIGITS * CODE_W;

  localparam logic [OUT_W-1:0] RST_CODE =
    {{(DISP_DIGITS-1){DIG_BLANK}}, 4'h0};

  logic [1:0]           state;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BIN_WIDTH-1:0] mag;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     cnt;
  logic                 sign;
  logic                 ovf;
  logic [OUT_W-1:0]     code;

  bcd_dabble_step #(
    .NDIG (BCD_DIGITS + 1)
  ) u_step (
    .bcd_in  (bcd),
    .bcd_out (bcd_adj)
  );

  assign BUSY = (state != S_IDLE);
  assign ovf  = (bcd[BCD_DIGITS*4 +: 4] != 4'h0);

  // Highest non-zero digit below the overflow digit sets
  // how many digits are shown; the minus sits just above.
  always_comb begin
    int msd;
    msd  = 0;
    code = '1;
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (bcd[i*4 +: 4] != 4'h0) msd = i;
    end
    for (int i = 0; i < DISP_DIGITS; i++) begin
      if (ovf || i <= msd)
        code[i*CODE_W +: CODE_W] = bcd[i*4 +: 4];
      else if (sign && i == msd + 1)
        code[i*CODE_W +: CODE_W] = DIG_MINUS;
      else
        code[i*CODE_W +: CODE_W] = DIG_BLANK;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      bin_q      <= '0;
      mag        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      sign       <= 1'b0;
      DONE       <= 1'b0;
      DIGIT_CODE <= RST_CODE;
      NEGATIVE   <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (CONVERT) begin
            bin_q <= BIN_IN;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          sign  <= bin_q[BIN_WIDTH-1];
          mag   <= bin_q[BIN_WIDTH-1] ? ~bin_q + 1'b1 : bin_q;
          bcd   <= '0;
          cnt   <= CNT_W'(BIN_WIDTH - 1);
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd <= {bcd_adj[BCD_W-2:0], mag[BIN_WIDTH-1]};
          mag <= {mag[BIN_WIDTH-2:0], 1'b0};
          if (cnt == '0) state <= S_FORMAT;
          else cnt <= cnt - 1'b1;
        end
        S_FORMAT: begin
          DIGIT_CODE <= code;
          NEGATIVE   <= sign;
          OVERFLOW   <= ovf;
          DONE       <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_result_display_formatter.sv
// Randomised and directed checks of the display formatter
// against an arithmetic model of the displayed result.
module tb_calc_result_display_formatter;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CONVERT = 1'b0;
  logic [17:0] BIN_IN = '0;
  logic        BUSY;
  logic        DONE;
  logic [23:0] DIGIT_CODE;
  logic        NEGATIVE;
  logic        OVERFLOW;

  int checks = 0;
  int failures = 0;

  calc_result_display_formatter dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .CONVERT    (CONVERT),
    .BIN_IN     (BIN_IN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .DIGIT_CODE (DIGIT_CODE),
    .NEGATIVE   (NEGATIVE),
    .OVERFLOW   (OVERFLOW)
  );

  always #10 CLK = ~CLK;

  // Returns {negative, overflow, codes[pos5..pos0]}.
  function automatic logic [25:0] fmt(input logic [17:0] v);
    int s, m, n, p;
    logic [23:0] c;
    logic neg, ovf;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    neg = (s < 0);
    ovf = (m >= 100000);
    n = 1;
    for (int t = m / 10; t > 0; t = t / 10) n++;
    c = '1;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      if (ovf || i < n) c[i*4 +: 4] = 4'((m / p) % 10);
      else if (neg && i == n) c[i*4 +: 4] = 4'hA;
      p = p * 10;
    end
    return {neg, ovf, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a conversion takes 20 edges from acceptance.
  int          m_cnt;
  logic [17:0] m_val;
  logic        m_done;
  logic [23:0] m_code;
  logic        m_neg;
  logic        m_ovf;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_cnt  <= 0;
      m_val  <= '0;
      m_done <= 1'b0;
      m_code <= 24'hFFFFF0;
      m_neg  <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (CONVERT) begin
          m_cnt <= 20;
          m_val <= BIN_IN;
        end
      end else begin
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          {m_neg, m_ovf, m_code} <= fmt(m_val);
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge CLK) begin
    chk("busy", 32'(BUSY), 32'(m_cnt != 0));
    chk("done", 32'(DONE), 32'(m_done));
    chk("code", 32'(DIGIT_CODE), 32'(m_code));
    chk("negative", 32'(NEGATIVE), 32'(m_neg));
    chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
  end

  task automatic run(input logic [17:0] v, input logic [23:0] ec,
                     input logic en, input logic eo);
    int k;
    BIN_IN  = v;
    CONVERT = 1'b1;
    @(posedge CLK); #1;
    CONVERT = 1'b0;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        k = i;
        break;
      end
    end
    chk("latency", 32'(k), 32'd20);
    chk("lit_code", 32'(DIGIT_CODE), 32'(ec));
    chk("lit_neg", 32'(NEGATIVE), 32'(en));
    chk("lit_ovf", 32'(OVERFLOW), 32'(eo));
    @(posedge CLK); #1;
  endtask

  initial begin
    int k;
    logic [17:0] v;
    chk("model_zero", 32'(fmt(18'd0)), 32'({2'b00, 24'hFFFFF0}));
    chk("model_m42", 32'(fmt(18'h3FFD6)), 32'({2'b10, 24'hFFFA42}));
    chk("model_m5", 32'(fmt(-18'sd5)), 32'({2'b10, 24'hFFFFA5}));
    chk("model_min", 32'(fmt(18'h20000)), 32'({2'b11, 24'h131072}));

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_code", 32'(DIGIT_CODE), 32'h00FFFFF0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    run(18'd0,      24'hFFFFF0, 1'b0, 1'b0);
    run(18'h3FFD6,  24'hFFFA42, 1'b1, 1'b0);
    run(-18'sd5,    24'hFFFFA5, 1'b1, 1'b0);
    run(18'd99999,  24'hF99999, 1'b0, 1'b0);
    run(18'd100000, 24'h100000, 1'b0, 1'b1);
    run(18'h20000,  24'h131072, 1'b1, 1'b1);
    run(-18'sd99999, 24'hA99999, 1'b1, 1'b0);

    // Extra CONVERT mid-conversion is dropped.
    BIN_IN = 18'd123; CONVERT = 1'b1;
    @(posedge CLK); #1;
    CONVERT = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    BIN_IN = 18'd777; CONVERT = 1'b1;
    @(posedge CLK); #1;
    CONVERT = 1'b0;
    k = 0;
    for (int i = 6; i <= 30; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        k = i;
        break;
      end
    end
    chk("ignored_lat", 32'(k), 32'd20);
    chk("ignored_code", 32'(DIGIT_CODE), 32'h00FFF123);
    repeat (25) @(posedge CLK);
    #1;
    chk("no_queue", 32'(DIGIT_CODE), 32'h00FFF123);
    run(18'd4096, 24'hFF4096, 1'b0, 1'b0);

    // Reset mid-conversion aborts without DONE.
    BIN_IN = 18'd55555; CONVERT = 1'b1;
    @(posedge CLK); #1;
    CONVERT = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    #2;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_code", 32'(DIGIT_CODE), 32'h00FFFFF0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    k = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge CLK); #1;
      if (DONE) k++;
    end
    chk("abort_done", 32'(k), 32'd0);
    run(18'h3FFFF, 24'hFFFFA1, 1'b1, 1'b0);

    // Random stimulus, including held CONVERT.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: v = 18'h20000;
        1: v = 18'd100000 + 18'($urandom_range(0, 3));
        2: v = 18'd99999 - 18'($urandom_range(0, 3));
        3: v = 18'($urandom_range(0, 20));
        4: v = -18'($urandom_range(0, 20));
        default: v = 18'($urandom);
      endcase
      BIN_IN  = v;
      CONVERT = ($urandom_range(0, 3) != 0);
      @(posedge CLK); #1;
    end
    CONVERT = 1'b0;
    repeat (25) @(posedge CLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
